// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment mux driver.
// Segment bit order is {g,f,e,d,c,b,a}, active low.
package sseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    // Entry n is the active-low pattern for hex digit n (entry 15 listed first).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/hex_digit_decoder.sv
// Combinational nibble-to-segment lookup (active low, gfedcba).
module hex_digit_decoder
    import sseg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = hex_to_seg(i_nib);

endmodule

// File: rtl/sseg_mux_driver.sv
// Time-multiplexed common-anode seven-segment driver with double-buffered data.
// Define SSEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module sseg_mux_driver
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] hex_vec,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    input  logic                    enable,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              sseg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    generate
        if (REFRESH_DIV < 2) begin : g_chk_div
            $error("sseg_mux_driver: REFRESH_DIV must be >= 2");
        end
        if (BLANK_CYCLES >= REFRESH_DIV) begin : g_chk_blank
            $error("sseg_mux_driver: BLANK_CYCLES must be < REFRESH_DIV");
        end
    endgenerate

    logic [CW-1:0]                r_cnt;
    logic [IW-1:0]                r_idx;
    logic [NUM_DIGITS-1:0][3:0]   r_pend_hex, r_act_hex, w_nxt_hex;
    logic [NUM_DIGITS-1:0]        r_pend_dp, r_pend_en, r_act_dp, r_act_en, r_act_blank;
    logic [NUM_DIGITS-1:0]        w_nxt_dp, w_nxt_en, w_nxt_blank;
    logic                         r_pend_flag;
    logic                         w_wrap, w_boundary, w_transfer, w_visible;
    logic [3:0]                   w_nib;
    logic [6:0]                   w_seg;

    assign w_wrap     = (r_cnt == CW'(REFRESH_DIV - 1));
    assign w_boundary = w_wrap && (r_idx == IW'(NUM_DIGITS - 1));
    assign w_transfer = w_boundary && (load || r_pend_flag);

    // A load in the boundary cycle itself goes straight to the active buffer.
    assign w_nxt_hex = load ? hex_vec  : r_pend_hex;
    assign w_nxt_dp  = load ? dp_in    : r_pend_dp;
    assign w_nxt_en  = load ? digit_en : r_pend_en;

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic v_run;
        w_nxt_blank = '0;
        v_run       = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (w_nxt_en[i]) begin
                if (v_run && (w_nxt_hex[i] == 4'h0) && !w_nxt_dp[i])
                    w_nxt_blank[i] = 1'b1;
                else
                    v_run = 1'b0;
            end
        end
    end
`else
    assign w_nxt_blank = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_hex  <= '0;
            r_pend_dp   <= '0;
            r_pend_en   <= '0;
            r_pend_flag <= 1'b0;
            r_act_hex   <= '0;
            r_act_dp    <= '0;
            r_act_en    <= '0;
            r_act_blank <= '0;
        end else begin
            if (load) begin
                r_pend_hex <= hex_vec;
                r_pend_dp  <= dp_in;
                r_pend_en  <= digit_en;
            end
            if (w_transfer) begin
                r_act_hex   <= w_nxt_hex;
                r_act_dp    <= w_nxt_dp;
                r_act_en    <= w_nxt_en;
                r_act_blank <= w_nxt_blank;
                r_pend_flag <= 1'b0;
            end else if (load) begin
                r_pend_flag <= 1'b1;
            end
        end
    end

    assign w_nib     = r_act_hex[r_idx];
    assign w_visible = enable && r_act_en[r_idx] && !r_act_blank[r_idx]
                       && (r_cnt >= CW'(BLANK_CYCLES));

    hex_digit_decoder u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= '1;
            sseg       <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_boundary;
            if (w_visible) begin
                an   <= ~(NUM_DIGITS'(1) << r_idx);
                sseg <= w_seg;
                dp   <= ~r_act_dp[r_idx];
            end else begin
                an   <= '1;
                sseg <= SEG_OFF;
                dp   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Directed bench for sseg_mux_driver: 4 digits, 8-cycle slots, 1 blank cycle.
// Load and check tables are keyed by the posedge count since reset release.
module tb_sseg_mux_driver;

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, load, enable;
    logic [15:0] hex_vec;
    logic [3:0]  dp_in, digit_en, an;
    logic [6:0]  sseg;
    logic        dp, frame_done;

    always #5 clk = ~clk;

    sseg_mux_driver #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .hex_vec    (hex_vec),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
        .enable     (enable),
        .an         (an),
        .sseg       (sseg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    typedef struct {int cyc; logic [15:0] hex; logic [3:0] dpv; logic [3:0] en;} ld_t;
    typedef struct {int cyc; logic [3:0] an; logic [6:0] seg; logic dp; logic fd;} chk_t;

    ld_t  lds[$];
    chk_t chks[$];
    int   cyc, checks, failures;
    bit   phase1;

    task automatic expect_out(input string nm, input logic [3:0] ean, input logic [6:0] eseg,
                              input logic edp, input logic efd);
        checks++;
        if (an !== ean || sseg !== eseg || dp !== edp || frame_done !== efd) begin
            failures++;
            $display("FAIL %s cyc=%0d got an=%h sseg=%h dp=%b fd=%b want an=%h sseg=%h dp=%b fd=%b",
                     nm, cyc, an, sseg, dp, frame_done, ean, eseg, edp, efd);
        end
    endtask

    function automatic void add_ld(int c, logic [15:0] h, logic [3:0] d, logic [3:0] e);
        ld_t t;
        t.cyc = c; t.hex = h; t.dpv = d; t.en = e;
        lds.push_back(t);
    endfunction

    function automatic void add_chk(int c, logic [3:0] a, logic [6:0] s, logic d, logic f);
        chk_t t;
        t.cyc = c; t.an = a; t.seg = s; t.dp = d; t.fd = f;
        chks.push_back(t);
    endfunction

    // Inputs are set at the negedge before edge cyc+1; outputs checked at the following negedge.
    task automatic tick();
        foreach (lds[i]) begin
            if (!phase1 && lds[i].cyc == cyc + 1) begin
                load     = 1'b1;
                hex_vec  = lds[i].hex;
                dp_in    = lds[i].dpv;
                digit_en = lds[i].en;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        load     = 1'b0;
        hex_vec  = 16'hDEAD;
        dp_in    = 4'hA;
        digit_en = 4'h5;
        foreach (chks[i]) begin
            if (!phase1 && chks[i].cyc == cyc)
                expect_out($sformatf("vec@%0d", cyc), chks[i].an, chks[i].seg, chks[i].dp, chks[i].fd);
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; enable = 1'b1;
        hex_vec = 16'hDEAD; dp_in = 4'hA; digit_en = 4'h5;
        cyc = 0; checks = 0; failures = 0; phase1 = 1'b0;

        add_ld(10,  16'h12AF, 4'b0100, 4'hF);
        add_ld(40,  16'h1234, 4'b0000, 4'hF);
        add_ld(60,  16'h5678, 4'b0000, 4'hF);
        add_ld(96,  16'h0F0F, 4'b0000, 4'hF);
        add_ld(150, 16'h0030, 4'b0000, 4'hF);
        add_ld(170, 16'h0000, 4'b0000, 4'hF);
        add_ld(200, 16'h0000, 4'b0100, 4'hF);
        add_ld(252, 16'h8888, 4'b0000, 4'hF);

        // frame 0: nothing active yet
        add_chk(1,   4'hF, 7'h7F, 1'b1, 1'b0);
        add_chk(16,  4'hF, 7'h7F, 1'b1, 1'b0);
        add_chk(32,  4'hF, 7'h7F, 1'b1, 1'b1);
        // frame 1: 12AF, dp on digit 2
        add_chk(33,  4'hF, 7'h7F, 1'b1, 1'b0);
        add_chk(34,  4'hE, 7'h0E, 1'b1, 1'b0);
        add_chk(40,  4'hE, 7'h0E, 1'b1, 1'b0);
        add_chk(41,  4'hF, 7'h7F, 1'b1, 1'b0);
        add_chk(42,  4'hD, 7'h08, 1'b1, 1'b0);
        add_chk(50,  4'hB, 7'h24, 1'b0, 1'b0);
        add_chk(57,  4'hF, 7'h7F, 1'b1, 1'b0);
        add_chk(58,  4'h7, 7'h79, 1'b1, 1'b0);
        add_chk(64,  4'h7, 7'h79, 1'b1, 1'b1);
        // frame 2: 5678 (1234 overwritten before the boundary)
        add_chk(66,  4'hE, 7'h00, 1'b1, 1'b0);
        add_chk(74,  4'hD, 7'h78, 1'b1, 1'b0);
        add_chk(82,  4'hB, 7'h02, 1'b1, 1'b0);
        add_chk(90,  4'h7, 7'h12, 1'b1, 1'b0);
        add_chk(96,  4'h7, 7'h12, 1'b1, 1'b1);
        // frame 3: 0F0F loaded on the boundary cycle
        add_chk(98,  4'hE, 7'h0E, 1'b1, 1'b0);
        add_chk(106, 4'hD, 7'h40, 1'b1, 1'b0);
        add_chk(114, 4'hB, 7'h0E, 1'b1, 1'b0);
        add_chk(122, LZB ? 4'hF : 4'h7, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0);
        add_chk(130, 4'hE, 7'h0E, 1'b1, 1'b0);
        // frame 5: 0030
        add_chk(162, 4'hE, 7'h40, 1'b1, 1'b0);
        add_chk(170, 4'hD, 7'h30, 1'b1, 1'b0);
        add_chk(178, LZB ? 4'hF : 4'hB, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0);
        add_chk(186, LZB ? 4'hF : 4'h7, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0);
        // frame 6: 0000
        add_chk(194, 4'hE, 7'h40, 1'b1, 1'b0);
        add_chk(202, LZB ? 4'hF : 4'hD, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0);
        add_chk(210, LZB ? 4'hF : 4'hB, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0);
        add_chk(218, LZB ? 4'hF : 4'h7, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0);
        // frame 7: 0000 with dp on digit 2 ending the zero run
        add_chk(226, 4'hE, 7'h40, 1'b1, 1'b0);
        add_chk(234, 4'hD, 7'h40, 1'b1, 1'b0);
        add_chk(242, 4'hB, 7'h40, 1'b0, 1'b0);
        add_chk(250, LZB ? 4'hF : 4'h7, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_out("reset_state", 4'hF, 7'h7F, 1'b1, 1'b0);
        reset = 1'b0;

        while (cyc < 131) tick();

        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_out("enable_low", 4'hF, 7'h7F, 1'b1, 1'b0);
        end
        enable = 1'b1;
        tick();
        expect_out("re_enable_pos", 4'hD, 7'h40, 1'b1, 1'b0);

        while (cyc < 254) tick();

        #2 reset = 1'b1;
        #1 expect_out("reset_async", 4'hF, 7'h7F, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        expect_out("reset_held", 4'hF, 7'h7F, 1'b1, 1'b0);
        reset  = 1'b0;
        cyc    = 0;
        phase1 = 1'b1;
        while (cyc < 34) begin
            tick();
            if (cyc == 32)
                expect_out("fd_after_reset", 4'hF, 7'h7F, 1'b1, 1'b1);
        end
        expect_out("pending_discarded", 4'hF, 7'h7F, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sseg_mux_driver.md
# sseg_mux_driver

Time-multiplexed driver for an N-digit common-anode seven-segment display. Holds a double-buffered hex value, scans one digit per refresh slot, decodes each nibble to segments, and drives active-low anode, segment and decimal-point pins. It sits between the status/telemetry logic and the board display pins, replacing per-digit static decoding with a single shared decoder and one refresh scan.

## Interface
- NUM_DIGITS, 8, number of digits scanned (1..16)
- REFRESH_DIV, 100000, clock cycles per digit slot (>= 2)
- BLANK_CYCLES, 2, anti-ghosting cycles at the start of each slot with all anodes off (< REFRESH_DIV)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- hex_vec  in  4*NUM_DIGITS  nibble per digit; digit i = hex_vec[4i+3:4i]; digit 0 is rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit, active high
- digit_en  in  NUM_DIGITS  per-digit display enable, active high
- load  in  1  one-cycle strobe; captures hex_vec, dp_in and digit_en into the pending buffer
- enable  in  1  global display enable; 0 forces all anodes off
- an  out  NUM_DIGITS  anode selects, active low, at most one low
- sseg  out  7  segments {g,f,e,d,c,b,a}, active low
- dp  out  1  decimal point, active low
- frame_done  out  1  one-cycle pulse after the last slot of each frame

## Operation
- Reset: an all 1, sseg 7'h7F, dp 1, frame_done 0; slot counter, digit index, pending/active buffers, pending flag all 0.
- Slot counter cnt counts 0..REFRESH_DIV-1, then wraps; on wrap, digit index idx advances, wrapping NUM_DIGITS-1 to 0.
- Frame boundary = cnt==REFRESH_DIV-1 and idx==NUM_DIGITS-1.
- load: pending buffer <= inputs, pending flag <= 1. Last load before a boundary wins.
- At a frame boundary with the pending flag set (or load in the same cycle): active buffer <= pending (including a same-cycle load), flag cleared. Display never changes mid-frame.
- Digit visible iff enable, active digit_en[idx], cnt >= BLANK_CYCLES, and not leading-zero blanked (see Configuration).
- Visible: an[idx]=0, sseg = decode(active nibble idx), dp = ~active dp[idx]. Otherwise an all 1, sseg 7'h7F, dp 1.
- Decode (active low, gfedcba): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
- enable low: counters and buffer transfer keep running; only outputs blank.
- Reset asserted mid-frame: immediate return to reset values, pending data discarded.

## Timing
- All outputs registered; they reflect cnt/idx of the previous cycle (1-cycle latency).
- frame_done high the cycle after the frame-boundary cycle.
- Active buffer change visible from the first slot (idx 0) of the next frame, after its blank cycles.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles; each digit lit REFRESH_DIV-BLANK_CYCLES cycles.

## Configuration
- SSEG_LEADING_ZERO_BLANK_EN defined: at buffer transfer, a registered blank mask is computed; enabled digits from index NUM_DIGITS-1 downward with nibble 0 are blanked until the first non-zero nibble or set dp; digit 0 is never blanked. Disabled digits are skipped (neither blanked by nor terminating the run).
- Undefined: no blank mask; every enabled digit is shown, zeros included.

## Structure
- Package sseg_pkg: 7-bit segment type, SEG_OFF constant 7'h7F, and the 16-entry hex-to-segment constant table.
- Sub-module hex_digit_decoder: combinational nibble-to-segment lookup using the package table; instanced once on the muxed nibble.
- Parameter checks (REFRESH_DIV >= 2, BLANK_CYCLES < REFRESH_DIV) as elaboration-time assertions.

## Test plan
Bench config: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=1.
- Release reset, no load -> an=4'hF, sseg=7'h7F, dp=1; frame_done every 32 cycles.
- load hex_vec=16'h12AF, digit_en=4'hF, dp_in=4'b0100 -> next frame: idx0 sseg=7'h0E, idx1 7'h08, idx2 7'h24 with dp=0, idx3 7'h79; each anode low 7 of 8 cycles.
- load 16'h1234 mid-frame, then 16'h5678 before boundary -> current frame unchanged; next frame shows 5678 only.
- load on the exact boundary cycle with 16'h0F0F -> shown in the immediately following frame.
- enable=0 for 10 cycles mid-slot -> an=4'hF during those cycles; scan position unchanged on re-enable; reset pulse mid-frame -> all outputs to reset values next cycle.
- With SSEG_LEADING_ZERO_BLANK_EN, load 16'h0030 -> digits 3,2 dark, digits 1,0 show 3 and 0; load 16'h0000 -> only digit 0 shows 0.
